vec_mul_sequencer: RTL and testbench
====================================

# vec_mul_sequencer

Run-level controller for the 1x64 vector-multiply datapath. On a start pulse it pops one weight set from the weight FIFO and pulses the array's weight reload. It then streams a programmed number of input-vector addresses into the unified buffer and writes each result into the results SRAM after the fixed array pipeline latency. It replaces host-driven sequencing of the FIFO, UB and results SRAM pins and signals completion with `end_`.

## Interface
- `ADDRESSSIZE`, 10: UB and results SRAM address width.
- `PIPE_LATENCY`, 10: cycles from a UB address being driven to the matching result being valid at the results SRAM input; must be at least 1.
- `STALL_CNT_BW`, 16: width of the optional stall counter.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  single-cycle run request; sampled only in IDLE.
- `vec_count`  in  ADDRESSSIZE  number of vectors in the run; latched on an accepted start.
- `src_base`  in  ADDRESSSIZE  first UB address; latched on an accepted start.
- `dst_base`  in  ADDRESSSIZE  first results SRAM address; latched on an accepted start.
- `fifo_empty`  in  1  weight FIFO empty flag.
- `fifo_read_enable`  out  1  pops one weight set.
- `weight_reload`  out  1  one-cycle weight latch pulse to the array.
- `ub_address`  out  ADDRESSSIZE  UB read address.
- `issue_valid`  out  1  `ub_address` carries a live vector this cycle.
- `res_write_enable`  out  1  results SRAM write strobe.
- `res_address`  out  ADDRESSSIZE  results SRAM write address.
- `busy`  out  1  high in every state except IDLE.
- `end_`  out  1  one-cycle run-complete pulse.
- `stall_count`  out  STALL_CNT_BW  weight-wait cycle count (see Configuration).

## Operation
- The controller is an FSM with states IDLE, WLOAD, RELOAD, STREAM, DRAIN and DONE.
- IDLE:
  - `start` with `vec_count`≠0 goes to WLOAD.
  - `start` with `vec_count`=0 goes straight to DONE, with no FIFO pop and no reload.
- WLOAD:
  - `fifo_read_enable` = !`fifo_empty` (combinational on state).
  - Goes to RELOAD on the cycle the pop occurs; otherwise holds indefinitely.
- RELOAD: `weight_reload`=1 for exactly one cycle, then goes to STREAM.
- STREAM:
  - Drives `issue_valid`=1 and `ub_address` = src_base + issue_cnt (mod 2^ADDRESSSIZE).
  - `issue_cnt` advances by one per cycle.
  - Goes to DRAIN after `vec_count` cycles.
- Write-back timing:
  - A PIPE_LATENCY-deep shift register delays `issue_valid` and drives `res_write_enable`.
  - `res_address` = dst_base + wr_cnt (mod 2^ADDRESSSIZE).
  - `wr_cnt` increments on each write.
  - Writes begin during STREAM whenever `vec_count` > PIPE_LATENCY.
- DRAIN: holds until the final write (wr_cnt = vec_count−1 with `res_write_enable`=1), then goes to DONE on the following edge.
- DONE: `end_`=1 for one cycle, then returns to IDLE.
- `start` outside IDLE is ignored. Live changes to `vec_count`, `src_base` or `dst_base` do not affect the current run.
- `vec_count`=2^ADDRESSSIZE−1 is legal. Addresses wrap modulo 2^ADDRESSSIZE.
- `rst` mid-run:
  - Returns the FSM to IDLE and clears the delay line, so no stale writes occur.
  - Clears all counters.
  - An in-flight FIFO pop is not replayed.

## Timing
- All outputs reset to 0. This covers `ub_address`, `res_address` and `stall_count`.
- Cycle numbering, with no FIFO stall and N = `vec_count`:
  - `start` is high in cycle 0.
  - WLOAD, with its pop, is cycle 1.
  - `weight_reload` is high in cycle 2.
  - Vector k (0 ≤ k < N) is issued in cycle 3+k and written in cycle 3+k+PIPE_LATENCY.
  - `end_` is high in cycle N+3+PIPE_LATENCY.
  - `busy` is low from cycle N+4+PIPE_LATENCY.
- Each FIFO-empty cycle in WLOAD shifts every later event by one cycle.
- With `vec_count`=0, `end_` is high in cycle 1.
- At most one pop and one reload occur per run.
- `fifo_read_enable` is never asserted while `fifo_empty`=1.

## Configuration
- `VEC_SEQ_STALL_CNT_EN` defined:
  - `stall_count` increments on every WLOAD cycle with `fifo_empty`=1 and saturates at all-ones.
  - It clears on an accepted `start` and is held after the run.
- Not defined: `stall_count` is tied to 0 and no counter logic is built.

## Test plan
- FIFO non-empty, `start` with N=4, src_base=0x010, dst_base=0x200, PIPE_LATENCY=10:
  - One pop in cycle 1 and `weight_reload` in cycle 2.
  - UB addresses 0x010–0x013 in cycles 3–6.
  - Writes to 0x200–0x203 in cycles 13–16.
  - `end_` in cycle 17 only.
- `fifo_empty`=1 for 5 cycles after `start`:
  - No pop during those cycles.
  - Every later event is delayed by 5 cycles.
  - `stall_count`=5 when the macro is defined, 0 otherwise.
- N=0: `end_` in cycle 1, with no pop, reload, issue or write.
- src_base=0x3FE, dst_base=0x3FF, N=3:
  - UB addresses 0x3FE, 0x3FF, 0x000.
  - Result addresses 0x3FF, 0x000, 0x001.
- `rst` asserted 2 cycles into STREAM, then a fresh `start` with N=2:
  - Outputs are 0 during reset.
  - No write from the aborted run appears.
  - The new run writes exactly 2 results.
- `start` pulsed during STREAM and again during DRAIN: no effect; exactly one `end_` pulse per accepted run.

Source files
------------

// File: rtl/vec_mul_sequencer_if.sv
// rtl/vec_mul_sequencer_if.sv - host, weight-FIFO, UB and results-SRAM signal bundle of the vector-multiply sequencer
interface vec_mul_sequencer_if #(
  parameter int ADDRESSSIZE  = 10,
  parameter int STALL_CNT_BW = 16
);
  // Run request from the host
  logic                    start;
  logic [ADDRESSSIZE-1:0]  vec_count;
  logic [ADDRESSSIZE-1:0]  src_base;
  logic [ADDRESSSIZE-1:0]  dst_base;

  // Weight FIFO and array control
  logic                    fifo_empty;
  logic                    fifo_read_enable;
  logic                    weight_reload;

  // Unified buffer read side
  logic [ADDRESSSIZE-1:0]  ub_address;
  logic                    issue_valid;

  // Results SRAM write side
  logic                    res_write_enable;
  logic [ADDRESSSIZE-1:0]  res_address;

  // Status
  logic                    busy;
  logic                    end_;
  logic [STALL_CNT_BW-1:0] stall_count;

  // Host / environment side: issues runs, owns the FIFO flag, observes everything
  modport master (
    output start, vec_count, src_base, dst_base, fifo_empty,
    input  fifo_read_enable, weight_reload, ub_address, issue_valid,
    input  res_write_enable, res_address, busy, end_, stall_count
  );

  // Sequencer side
  modport slave (
    input  start, vec_count, src_base, dst_base, fifo_empty,
    output fifo_read_enable, weight_reload, ub_address, issue_valid,
    output res_write_enable, res_address, busy, end_, stall_count
  );
endinterface

// File: rtl/vec_mul_sequencer.sv
// rtl/vec_mul_sequencer.sv - run-level controller for the 1x64 vector-multiply datapath (optional stall counter: VEC_SEQ_STALL_CNT_EN)
module vec_mul_sequencer #(
  parameter int ADDRESSSIZE  = 10,
  parameter int PIPE_LATENCY = 10,
  parameter int STALL_CNT_BW = 16
) (
  input logic               clk,
  input logic               rst,
  vec_mul_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WLOAD  = 3'd1,
    RELOAD = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [ADDRESSSIZE-1:0] ADDR_ONE = {{(ADDRESSSIZE-1){1'b0}}, 1'b1};

  state_t state;
  state_t state_next;

  // Run parameters captured at the accepted start so live input changes are ignored
  logic [ADDRESSSIZE-1:0] n_reg;
  logic [ADDRESSSIZE-1:0] src_reg;
  logic [ADDRESSSIZE-1:0] dst_reg;

  logic [ADDRESSSIZE-1:0] issue_cnt;
  logic [ADDRESSSIZE-1:0] wr_cnt;
  logic [ADDRESSSIZE-1:0] last_index;

  // Delay line matching the array pipeline; bit PIPE_LATENCY-1 is the write strobe
  logic [PIPE_LATENCY-1:0] dly;

  logic start_accept;
  logic pop;
  logic reload;
  logic issue;
  logic wr_en;
  logic last_issue;
  logic last_write;

  assign last_index = n_reg - ADDR_ONE;
  assign wr_en      = dly[PIPE_LATENCY-1];
  assign last_issue = (issue_cnt == last_index);
  assign last_write = wr_en && (wr_cnt == last_index);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-state strobes
  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    pop          = 1'b0;
    reload       = 1'b0;
    issue        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          start_accept = 1'b1;
          // An empty run skips the weight load entirely
          state_next   = (bus.vec_count == '0) ? DONE : WLOAD;
        end
      end
      WLOAD: begin
        // Pop only when a weight set is present; otherwise wait here
        pop = !bus.fifo_empty;
        if (pop) begin
          state_next = RELOAD;
        end
      end
      RELOAD: begin
        reload     = 1'b1;
        state_next = STREAM;
      end
      STREAM: begin
        issue = 1'b1;
        if (last_issue) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_write) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch run parameters on an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg   <= '0;
      src_reg <= '0;
      dst_reg <= '0;
    end else if (start_accept) begin
      n_reg   <= bus.vec_count;
      src_reg <= bus.src_base;
      dst_reg <= bus.dst_base;
    end
  end

  // Issue counter: offset of the vector currently driven on the UB address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
    end else if (start_accept) begin
      issue_cnt <= '0;
    end else if (issue) begin
      issue_cnt <= issue_cnt + ADDR_ONE;
    end
  end

  // Write counter: offset of the next result written to the results SRAM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
    end else if (start_accept) begin
      wr_cnt <= '0;
    end else if (wr_en) begin
      wr_cnt <= wr_cnt + ADDR_ONE;
    end
  end

  // Pipeline-latency delay of issue_valid; cleared by reset so aborted runs leave no writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly <= '0;
    end else begin
      dly[0] <= issue;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

`ifdef VEC_SEQ_STALL_CNT_EN
  localparam logic [STALL_CNT_BW-1:0] STALL_ONE = {{(STALL_CNT_BW-1){1'b0}}, 1'b1};

  logic [STALL_CNT_BW-1:0] stall_reg;

  // Count weight-wait cycles in WLOAD, saturating; kept after the run for the host to read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_reg <= '0;
    end else if (start_accept) begin
      stall_reg <= '0;
    end else if ((state == WLOAD) && bus.fifo_empty && (stall_reg != '1)) begin
      stall_reg <= stall_reg + STALL_ONE;
    end
  end

  assign bus.stall_count = stall_reg;
`else
  assign bus.stall_count = '0;
`endif

  // Addresses are forced to zero when their strobe is idle
  assign bus.fifo_read_enable = pop;
  assign bus.weight_reload    = reload;
  assign bus.issue_valid      = issue;
  assign bus.ub_address       = issue ? (src_reg + issue_cnt) : '0;
  assign bus.res_write_enable = wr_en;
  assign bus.res_address      = wr_en ? (dst_reg + wr_cnt) : '0;
  assign bus.busy             = (state != IDLE);
  assign bus.end_             = (state == DONE);

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// tb/tb_vec_mul_sequencer.sv - scoreboard bench for vec_mul_sequencer
module tb_vec_mul_sequencer;

  localparam int A = 10;
  localparam int L = 10;
  localparam int W = 16;

  typedef struct {
    int          cyc;
    logic [A-1:0] addr;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ev_t exp_pop[$];
  ev_t exp_rel[$];
  ev_t exp_ub[$];
  ev_t exp_res[$];
  ev_t exp_end[$];

  vec_mul_sequencer_if #(.ADDRESSSIZE(A), .STALL_CNT_BW(W)) bus ();

  vec_mul_sequencer #(
    .ADDRESSSIZE (A),
    .PIPE_LATENCY(L),
    .STALL_CNT_BW(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic pop_ev(input string name, inout ev_t q[$], input logic [A-1:0] act_addr);
    ev_t e;
    if (q.size() == 0) begin
      chk({name, "_unexpected"}, 1, 0);
    end else begin
      e = q.pop_front();
      chk({name, "_cycle"}, cyc, e.cyc);
      chk({name, "_addr"}, act_addr, e.addr);
    end
  endtask

  // Monitor: every strobe observed must match the next expected event
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fifo_read_enable) begin
        chk("pop_while_empty", bus.fifo_empty, 0);
        pop_ev("pop", exp_pop, '0);
      end
      if (bus.weight_reload) pop_ev("reload", exp_rel, '0);
      if (bus.issue_valid) pop_ev("issue", exp_ub, bus.ub_address);
      if (bus.res_write_enable) pop_ev("write", exp_res, bus.res_address);
      if (bus.end_) pop_ev("end", exp_end, '0);
    end
  end

  function automatic ev_t mk(input int c, input logic [A-1:0] a);
    ev_t e;
    e.cyc  = c;
    e.addr = a;
    return e;
  endfunction

  task automatic check_reset_outputs();
    chk("rst_outputs",
        {bus.fifo_read_enable, bus.weight_reload, bus.issue_valid, bus.res_write_enable,
         bus.busy, bus.end_, bus.ub_address, bus.res_address, bus.stall_count}, 0);
  endtask

  // Reference model: a run of n vectors after s empty-FIFO cycles, started in cycle c0
  task automatic expect_run(input int c0, input int n, input int s,
                            input logic [A-1:0] src, input logic [A-1:0] dst, input int keep_issues);
    if (n == 0) begin
      exp_end.push_back(mk(c0 + 1, '0));
      return;
    end
    exp_pop.push_back(mk(c0 + 1 + s, '0));
    exp_rel.push_back(mk(c0 + 2 + s, '0));
    for (int k = 0; k < n && k < keep_issues; k++) begin
      exp_ub.push_back(mk(c0 + 3 + s + k, A'(src + k)));
    end
    if (keep_issues >= n) begin
      for (int k = 0; k < n; k++) exp_res.push_back(mk(c0 + 3 + s + k + L, A'(dst + k)));
      exp_end.push_back(mk(c0 + 3 + s + n + L, '0));
    end
  endtask

  // Per-cycle environment during a run: weight FIFO stall then random noise on ignored inputs
  task automatic env_cycle(input int c0, input int n, input int s);
    bus.start     = ($urandom_range(0, 3) == 0);
    bus.vec_count = A'($urandom);
    bus.src_base  = A'($urandom);
    bus.dst_base  = A'($urandom);
    if (n != 0 && cyc <= c0 + s) bus.fifo_empty = 1'b1;
    else if (n != 0 && cyc == c0 + s + 1) bus.fifo_empty = 1'b0;
    else bus.fifo_empty = $urandom_range(0, 1);
  endtask

  task automatic run(input int n, input logic [A-1:0] src, input logic [A-1:0] dst, input int s);
    int c0;
    int endc;
    @(posedge clk); #1;
    c0 = cyc;
    bus.start      = 1'b1;
    bus.vec_count  = A'(n);
    bus.src_base   = src;
    bus.dst_base   = dst;
    bus.fifo_empty = (s > 0);
    expect_run(c0, n, s, src, dst, n);
    endc = (n == 0) ? c0 + 1 : c0 + 3 + s + n + L;
    while (cyc < endc) begin
      @(posedge clk); #1;
      env_cycle(c0, n, s);
      if (cyc == endc) chk("busy_at_end", bus.busy, 1);
    end
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.fifo_empty = 1'b0;
    chk("busy_after_end", bus.busy, 0);
`ifdef VEC_SEQ_STALL_CNT_EN
    chk("stall_count", bus.stall_count, (n == 0) ? 0 : s);
`else
    chk("stall_count", bus.stall_count, 0);
`endif
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  // Run of n vectors aborted by reset after two STREAM issues
  task automatic run_abort(input int n, input logic [A-1:0] src, input logic [A-1:0] dst);
    int c0;
    @(posedge clk); #1;
    c0 = cyc;
    bus.start      = 1'b1;
    bus.vec_count  = A'(n);
    bus.src_base   = src;
    bus.dst_base   = dst;
    bus.fifo_empty = 1'b0;
    expect_run(c0, n, 0, src, dst, 2);
    while (cyc < c0 + 4) begin
      @(posedge clk); #1;
      env_cycle(c0, n, 0);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs();
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.vec_count  = '0;
    bus.src_base   = '0;
    bus.dst_base   = '0;
    bus.fifo_empty = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", bus.busy, 0);

    run(4, 10'h010, 10'h200, 0);
    run(4, 10'h010, 10'h200, 5);
    run(0, 10'h123, 10'h321, 0);
    run(3, 10'h3FE, 10'h3FF, 0);
    run(1, 10'h3FF, 10'h000, 2);
    run(L, 10'h055, 10'h0AA, 0);
    run(L + 1, 10'h155, 10'h2AA, 1);
    run_abort(6, 10'h040, 10'h140);
    run(2, 10'h070, 10'h170, 0);
    for (int i = 0; i < 20; i++) begin
      run($urandom_range(0, 40), A'($urandom), A'($urandom), $urandom_range(0, 6));
    end
    run(1023, 10'h001, 10'h3F0, 3);

    repeat (L + 5) @(posedge clk);
    chk("pending_pop", exp_pop.size(), 0);
    chk("pending_reload", exp_rel.size(), 0);
    chk("pending_issue", exp_ub.size(), 0);
    chk("pending_write", exp_res.size(), 0);
    chk("pending_end", exp_end.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
